// File: rtl/lock_rst_seq.sv
// Staged active-low reset sequencer driven by a clocking-wizard lock indication.
// Optional macro LOCK_LOSS_CNT_EN enables the saturating lock-loss counter.
module lock_rst_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_locked,
  input  logic       i_soft_rst,
  output logic [2:0] o_rst_n,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_lock_loss_cnt
);

  localparam int MAX_CNT = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STABLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  logic [1:0]    sync_r;
  logic          locked_s;
  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [2:0]    rst_n_r;
  logic [2:0]    rst_n_s;
  logic          ready_r;
  logic          ready_s;

  assign locked_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], i_locked};
    end
  end

  // FSM state, window/gap counter and registered outputs
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rst_n_r <= 3'b000;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rst_n_r <= rst_n_s;
      ready_r <= ready_s;
    end
  end

  // Next-state logic: lock loss beats soft reset beats normal progression
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rst_n_s = rst_n_r;
    ready_s = ready_r;
    case (state_r)
      IDLE: begin
        rst_n_s = 3'b000;
        ready_s = 1'b0;
        cnt_s   = '0;
        if (locked_s) begin
          state_s = STABLE;
        end else begin
          state_s = IDLE;
        end
      end
      STABLE: begin
        rst_n_s = 3'b000;
        ready_s = 1'b0;
        if (!locked_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == STABLE_LAST) begin
          state_s = RELEASE;
          cnt_s   = '0;
          rst_n_s = 3'b001;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_s = IDLE;
          cnt_s   = '0;
          rst_n_s = 3'b000;
          ready_s = 1'b0;
        end else if (i_soft_rst) begin
          state_s = STABLE;
          cnt_s   = '0;
          rst_n_s = 3'b000;
          ready_s = 1'b0;
        end else if (state_r == RUN) begin
          cnt_s   = '0;
          rst_n_s = 3'b111;
          ready_s = 1'b1;
        end else if (cnt_r == GAP_LAST) begin
          cnt_s = '0;
          // Stage 1 still held means this gap releases stage 1, otherwise stage 2
          if (!rst_n_r[1]) begin
            rst_n_s = 3'b011;
          end else begin
            rst_n_s = 3'b111;
            ready_s = 1'b1;
            state_s = RUN;
          end
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        rst_n_s = 3'b000;
        ready_s = 1'b0;
      end
    endcase
  end

  assign o_rst_n = rst_n_r;
  assign o_ready = ready_r;
  assign o_state = state_r;

`ifdef LOCK_LOSS_CNT_EN
  logic       loss_inc_s;
  logic [7:0] loss_cnt_r;

  assign loss_inc_s = !locked_s && ((state_r == RELEASE) || (state_r == RUN));

  // Saturating count of lock losses after the first stage was released
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loss_cnt_r <= 8'd0;
    end else if (loss_inc_s && (loss_cnt_r != 8'd255)) begin
      loss_cnt_r <= loss_cnt_r + 8'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign o_lock_loss_cnt = loss_cnt_r;
`else
  assign o_lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lock_rst_seq.sv
// Directed self-checking bench for lock_rst_seq with STABLE_CYCLES=8, STAGE_GAP=4.
module tb_lock_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       locked;
  logic       soft_rst;
  logic [2:0] o_rst_n;
  logic       o_ready;
  logic [1:0] o_state;
  logic [7:0] o_lock_loss_cnt;

  int tests;
  int fails;
  int exp_loss;

  lock_rst_seq #(.STABLE_CYCLES(8), .STAGE_GAP(4)) dut (
    .i_sys_clk       (clk),
    .i_rst_n         (rst_n),
    .i_locked        (locked),
    .i_soft_rst      (soft_rst),
    .o_rst_n         (o_rst_n),
    .o_ready         (o_ready),
    .o_state         (o_state),
    .o_lock_loss_cnt (o_lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bump_loss();
`ifdef LOCK_LOSS_CNT_EN
    if (exp_loss < 255) exp_loss++;
`endif
  endtask

  // Expects IDLE with a flushed synchronizer; raises locked, walks to RUN
  task automatic run_lock_seq(input string name, input bit soft_in_stable);
    locked = 1'b1;
    tick(1);   // edge 0
    tick(2);   // edge 2
    tests++; if (o_state !== 2'd1) begin fails++; $display("FAIL %s_stable: o_state=%0d exp=1", name, o_state); end
    if (soft_in_stable) begin
      tick(3); // edge 5
      soft_rst = 1'b1;
      tick(1); // edge 6
      soft_rst = 1'b0;
      tick(3); // edge 9
    end else begin
      tick(7); // edge 9
    end
    tests++; if (o_rst_n !== 3'b000 || o_state !== 2'd1) begin fails++; $display("FAIL %s_e9: o_rst_n=%b o_state=%0d exp=000/1", name, o_rst_n, o_state); end
    tick(1);   // edge 10
    tests++; if (o_rst_n !== 3'b001 || o_state !== 2'd2) begin fails++; $display("FAIL %s_e10: o_rst_n=%b o_state=%0d exp=001/2", name, o_rst_n, o_state); end
    tick(3);   // edge 13
    tests++; if (o_rst_n !== 3'b001) begin fails++; $display("FAIL %s_e13: o_rst_n=%b exp=001", name, o_rst_n); end
    tick(1);   // edge 14
    tests++; if (o_rst_n !== 3'b011 || o_state !== 2'd2) begin fails++; $display("FAIL %s_e14: o_rst_n=%b o_state=%0d exp=011/2", name, o_rst_n, o_state); end
    tick(3);   // edge 17
    tests++; if (o_rst_n !== 3'b011 || o_ready !== 1'b0) begin fails++; $display("FAIL %s_e17: o_rst_n=%b o_ready=%b exp=011/0", name, o_rst_n, o_ready); end
    tick(1);   // edge 18
    tests++; if (o_rst_n !== 3'b111 || o_ready !== 1'b1 || o_state !== 2'd3) begin fails++; $display("FAIL %s_e18: o_rst_n=%b o_ready=%b o_state=%0d exp=111/1/3", name, o_rst_n, o_ready, o_state); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; locked = 1'b0; soft_rst = 1'b0;
    tick(3);
    tests++; if (o_rst_n !== 3'b000 || o_ready !== 1'b0 || o_state !== 2'd0 || o_lock_loss_cnt !== 8'd0) begin
      fails++; $display("FAIL reset: rst=%b rdy=%b st=%0d cnt=%0d exp=000/0/0/0", o_rst_n, o_ready, o_state, o_lock_loss_cnt);
    end
    #3 rst_n = 1'b1;
    tick(2);
    tests++; if (o_state !== 2'd0 || o_rst_n !== 3'b000) begin fails++; $display("FAIL reset_idle: st=%0d rst=%b exp=0/000", o_state, o_rst_n); end
  endtask

  task automatic test_clean_lock();
    run_lock_seq("clean", 1'b0);
  endtask

  task automatic test_loss_run();
    locked = 1'b0;
    tick(2);   // edges A, A+1
    tests++; if (o_rst_n !== 3'b111 || o_state !== 2'd3) begin fails++; $display("FAIL loss_hold: rst=%b st=%0d exp=111/3", o_rst_n, o_state); end
    tick(1);   // edge A+2
    bump_loss();
    tests++; if (o_rst_n !== 3'b000 || o_ready !== 1'b0 || o_state !== 2'd0 || o_lock_loss_cnt !== 8'(exp_loss)) begin
      fails++; $display("FAIL loss_run: rst=%b rdy=%b st=%0d cnt=%0d exp=000/0/0/%0d", o_rst_n, o_ready, o_state, o_lock_loss_cnt, exp_loss);
    end
    run_lock_seq("relock", 1'b0);
  endtask

  task automatic test_soft_run();
    soft_rst = 1'b1;
    tick(1);   // edge E
    soft_rst = 1'b0;
    tests++; if (o_rst_n !== 3'b000 || o_state !== 2'd1 || o_ready !== 1'b0) begin fails++; $display("FAIL soft_run: rst=%b st=%0d rdy=%b exp=000/1/0", o_rst_n, o_state, o_ready); end
    tick(7);
    tests++; if (o_rst_n !== 3'b000 || o_state !== 2'd1) begin fails++; $display("FAIL soft_window: rst=%b st=%0d exp=000/1", o_rst_n, o_state); end
    tick(1);   // E+8
    tests++; if (o_rst_n !== 3'b001) begin fails++; $display("FAIL soft_r0: rst=%b exp=001", o_rst_n); end
    tick(7);   // E+15
    tests++; if (o_rst_n !== 3'b011) begin fails++; $display("FAIL soft_r1: rst=%b exp=011", o_rst_n); end
    tick(1);   // E+16
    tests++; if (o_rst_n !== 3'b111 || o_ready !== 1'b1) begin fails++; $display("FAIL soft_done: rst=%b rdy=%b exp=111/1", o_rst_n, o_ready); end
    tests++; if (o_lock_loss_cnt !== 8'(exp_loss)) begin fails++; $display("FAIL soft_cnt: cnt=%0d exp=%0d", o_lock_loss_cnt, exp_loss); end
  endtask

  task automatic test_soft_in_stable();
    locked = 1'b0;
    tick(3);
    bump_loss();
    run_lock_seq("soft_stable", 1'b1);
  endtask

  task automatic test_glitch_stable();
    locked = 1'b0;
    tick(3);
    bump_loss();
    locked = 1'b1;
    tick(1);   // edge 0
    tick(4);   // edge 4
    locked = 1'b0;
    tick(2);   // edges 5,6 sample low
    locked = 1'b1;
    tick(1);   // edge 7
    tests++; if (o_state !== 2'd0 || o_rst_n !== 3'b000 || o_lock_loss_cnt !== 8'(exp_loss)) begin
      fails++; $display("FAIL glitch_idle: st=%0d rst=%b cnt=%0d exp=0/000/%0d", o_state, o_rst_n, o_lock_loss_cnt, exp_loss);
    end
    tick(2);   // edge 9
    tests++; if (o_state !== 2'd1) begin fails++; $display("FAIL glitch_restable: st=%0d exp=1", o_state); end
    tick(7);   // edge 16
    tests++; if (o_rst_n !== 3'b000 || o_state !== 2'd1) begin fails++; $display("FAIL glitch_window: rst=%b st=%0d exp=000/1", o_rst_n, o_state); end
    tick(1);   // edge 17
    tests++; if (o_rst_n !== 3'b001 || o_state !== 2'd2) begin fails++; $display("FAIL glitch_r0: rst=%b st=%0d exp=001/2", o_rst_n, o_state); end
    tick(8);   // edge 25
    tests++; if (o_rst_n !== 3'b111 || o_ready !== 1'b1) begin fails++; $display("FAIL glitch_run: rst=%b rdy=%b exp=111/1", o_rst_n, o_ready); end
  endtask

  task automatic test_simultaneous();
    locked = 1'b0;
    tick(2);   // locked_s low after A+1
    soft_rst = 1'b1;
    tick(1);   // edge A+2
    soft_rst = 1'b0;
    bump_loss();
    tests++; if (o_state !== 2'd0 || o_rst_n !== 3'b000 || o_lock_loss_cnt !== 8'(exp_loss)) begin
      fails++; $display("FAIL simul: st=%0d rst=%b cnt=%0d exp=0/000/%0d", o_state, o_rst_n, o_lock_loss_cnt, exp_loss);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 300; k++) begin
      locked = 1'b1;
      tick(11);  // reaches RELEASE at edge 10
      locked = 1'b0;
      tick(3);
      bump_loss();
    end
`ifdef LOCK_LOSS_CNT_EN
    tests++; if (o_lock_loss_cnt !== 8'd255) begin fails++; $display("FAIL saturate: cnt=%0d exp=255", o_lock_loss_cnt); end
`else
    tests++; if (o_lock_loss_cnt !== 8'd0) begin fails++; $display("FAIL cnt_disabled: cnt=%0d exp=0", o_lock_loss_cnt); end
`endif
    tests++; if (o_lock_loss_cnt !== 8'(exp_loss)) begin fails++; $display("FAIL sat_model: cnt=%0d exp=%0d", o_lock_loss_cnt, exp_loss); end
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    tick(15);  // edge 14: stages 0 and 1 released
    tests++; if (o_rst_n !== 3'b011) begin fails++; $display("FAIL async_pre: rst=%b exp=011", o_rst_n); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (o_rst_n !== 3'b000 || o_ready !== 1'b0 || o_state !== 2'd0 || o_lock_loss_cnt !== 8'd0) begin
      fails++; $display("FAIL async_rst: rst=%b rdy=%b st=%0d cnt=%0d exp=000/0/0/0", o_rst_n, o_ready, o_state, o_lock_loss_cnt);
    end
    exp_loss = 0;
    tick(2);
    locked = 1'b0;
    #2 rst_n = 1'b1;
    tick(3);
    tests++; if (o_state !== 2'd0 || o_rst_n !== 3'b000) begin fails++; $display("FAIL async_idle: st=%0d rst=%b exp=0/000", o_state, o_rst_n); end
  endtask

  initial begin
    tests = 0; fails = 0; exp_loss = 0;
    test_reset();
    test_clean_lock();
    test_loss_run();
    test_soft_run();
    test_soft_in_stable();
    test_glitch_stable();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
